// File: rtl/retire_free_queue.sv
// Retire-side free-list feeder: absorbs up to RETIRE_WIDTH released tags per cycle
// into a circular FIFO and drains one tag per cycle into the free list.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module retire_free_queue #(
    parameter int RETIRE_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int TAG_W        = $clog2(`PHYS_REG_SZ),
    parameter int DROP_ZERO    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RETIRE_WIDTH-1:0]       retire_valid,
    input  logic [RETIRE_WIDTH*TAG_W-1:0] retire_told,
    output logic                          retire_ready,
    input  logic                          fl_full,
    output logic                          fl_push,
    output logic [TAG_W-1:0]              fl_tag,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RW_C    = CNT_W'(RETIRE_WIDTH);

    logic [TAG_W-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;

    logic                    w_ready;
    logic                    w_empty;
    logic                    w_push;
    logic [RETIRE_WIDTH-1:0] w_elig;
    logic [CNT_W-1:0]        w_n_enq;
    logic [CNT_W-1:0]        w_n_acc;
    logic [PTR_W-1:0]        w_waddr [RETIRE_WIDTH];

    // Ready is judged from registered occupancy only; a same-cycle drain earns no credit.
    assign w_ready = (DEPTH_C - r_count) >= RW_C;
    assign w_empty = (r_count == '0);
    assign w_push  = !w_empty && !fl_full;

    // Compact eligible lanes in lane order onto consecutive slots starting at tail.
    always_comb begin
        w_n_enq = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            w_elig[i]  = retire_valid[i] &&
                         !((DROP_ZERO != 0) && (retire_told[i*TAG_W +: TAG_W] == '0));
            w_waddr[i] = r_tail + w_n_enq[PTR_W-1:0];
            if (w_elig[i]) begin
                w_n_enq = w_n_enq + 1'b1;
            end
        end
    end

    assign w_n_acc = w_ready ? w_n_enq : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tail  <= r_tail + w_n_acc[PTR_W-1:0];
            r_count <= r_count + w_n_acc - CNT_W'(w_push);
            if (w_push) begin
                r_head <= r_head + 1'b1;
            end
            if (!w_ready && (|retire_valid)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_ready) begin
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                if (w_elig[i]) begin
                    r_mem[w_waddr[i]] <= retire_told[i*TAG_W +: TAG_W];
                end
            end
        end
    end

    assign retire_ready = w_ready;
    assign fl_push      = w_push;
    assign fl_tag       = r_mem[r_head];
    assign count        = r_count;
    assign empty        = w_empty;
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_retire_free_queue.sv
// Randomized bench for retire_free_queue against a queue-based reference model.
module tb_retire_free_queue;

    localparam int RW    = 2;
    localparam int DEPTH = 8;
    localparam int TAG_W = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [RW-1:0]        retire_valid;
    logic [RW*TAG_W-1:0]  retire_told;
    logic                 retire_ready;
    logic                 fl_full;
    logic                 fl_push;
    logic [TAG_W-1:0]     fl_tag;
    logic [$clog2(DEPTH):0] count;
    logic                 empty;
    logic                 overflow_err;

    retire_free_queue #(
        .RETIRE_WIDTH(RW), .DEPTH(DEPTH), .TAG_W(TAG_W), .DROP_ZERO(1)
    ) dut (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_told(retire_told),
        .retire_ready(retire_ready), .fl_full(fl_full), .fl_push(fl_push), .fl_tag(fl_tag),
        .count(count), .empty(empty), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: tags in retirement order, plus sticky error flag.
    int m_q[$];
    bit m_err  = 1'b0;
    bit m_live = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit m_ready();
        return (DEPTH - m_q.size()) >= RW;
    endfunction

    task automatic step(input bit rst, input logic [RW-1:0] v, input int t0, input int t1,
                        input bit full);
        bit exp_push;
        int tags[RW];
        @(negedge clk);
        reset        = rst;
        retire_valid = v;
        retire_told  = {TAG_W'(t1), TAG_W'(t0)};
        fl_full      = full;
        tags[0] = t0;
        tags[1] = t1;
        #1;
        exp_push = (m_q.size() != 0) && !full;
        if (m_live) begin
            check("count", 32'(count), 32'(m_q.size()));
            check("empty", 32'(empty), 32'(m_q.size() == 0));
            check("ready", 32'(retire_ready), 32'(m_ready()));
            check("push", 32'(fl_push), 32'(exp_push));
            check("oflow", 32'(overflow_err), 32'(m_err));
            if (m_q.size() != 0) check("tag", 32'(fl_tag), 32'(m_q[0]));
        end
        if (rst) begin
            m_q.delete();
            m_err  = 1'b0;
            m_live = 1'b1;
        end else begin
            if (m_ready()) begin
                if (exp_push) void'(m_q.pop_front());
                for (int i = 0; i < RW; i++)
                    if (v[i] && tags[i] != 0) m_q.push_back(tags[i]);
            end else begin
                if (exp_push) void'(m_q.pop_front());
                if (|v) m_err = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit full);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 0, 0, full);
    endtask

    initial begin
        reset = 1'b1; retire_valid = '0; retire_told = '0; fl_full = 1'b0;
        step(1'b1, 2'b00, 0, 0, 1'b0);
        step(1'b1, 2'b00, 0, 0, 1'b0);

        // Pass-through, dual retire, zero filter and interleaved lane.
        step(1'b0, 2'b01, 7, 0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 2'b11, 5, 9, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 2'b11, 0, 12, 1'b0);
        step(1'b0, 2'b10, 0, 3, 1'b0);
        idle(3, 1'b0);

        // Backpressure fill to DEPTH, then release.
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11, 2*k+1, 2*k+2, 1'b1);
        idle(2, 1'b1);
        idle(10, 1'b0);

        // Stream two per cycle while draining one, wrapping many times.
        for (int k = 0; k < 40; k++) begin
            if (m_ready()) step(1'b0, 2'b11, $urandom_range(1, 63), $urandom_range(1, 63), 1'b0);
            else           step(1'b0, 2'b00, 0, 0, 1'b0);
        end
        idle(10, 1'b0);

        // Fully random traffic, mostly legal.
        for (int k = 0; k < 300; k++) begin
            logic [RW-1:0] v;
            int a, b;
            v = RW'($urandom_range(0, 3));
            if (!m_ready() && ($urandom_range(0, 19) != 0)) v = '0;
            a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
            b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
            step(1'b0, v, a, b, $urandom_range(0, 3) == 0);
        end

        // Protocol error while not ready, then sticky.
        step(1'b1, 2'b00, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11, 10 + k, 20 + k, 1'b1);
        step(1'b0, 2'b01, 33, 0, 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);

        // Reset with five entries buffered.
        step(1'b1, 2'b00, 0, 0, 1'b0);
        step(1'b0, 2'b11, 41, 42, 1'b1);
        step(1'b0, 2'b11, 43, 44, 1'b1);
        step(1'b0, 2'b01, 45, 0, 1'b1);
        step(1'b1, 2'b00, 0, 0, 1'b0);
        idle(3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
